// File: rtl/cpll_pkg.sv
// cpll_pkg: shared constants and helpers for the cpll clock generator.
//   CPLL_DEF_C0_DIV       default inclk0 -> c0 divide ratio
//   CPLL_DEF_LOCK_CYCLES  default rising edges from reset release to lock
//   gate_pol_e            clock gate polarity (true or inverted reference)
//   cpll_cnt_width()      ceil(log2(n)), never less than 1
package cpll_pkg;

   localparam int CPLL_DEF_C0_DIV      = 2;
   localparam int CPLL_DEF_LOCK_CYCLES = 16;

   typedef enum logic {
      GATE_TRUE = 1'b0,
      GATE_INV  = 1'b1
   } gate_pol_e;

   function automatic int unsigned cpll_cnt_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cpll_if.sv
// cpll_if: bundle of the generated clocks and lock status.
//   c0      divided video clock
//   c1      gated memory clock
//   c2      gated auxiliary memory clock
//   locked  outputs valid and stable
// master: driven by cpll; slave: consumers of the clocks.
interface cpll_if;

   logic c0;
   logic c1;
   logic c2;
   logic locked;

   modport master (output c0, output c1, output c2, output locked);
   modport slave  (input  c0, input  c1, input  c2, input  locked);

endinterface

// File: rtl/cpll_clk_gate.sv
// cpll_clk_gate: glitch-free clock gate.
//   clk       reference clock
//   areset_n  asynchronous active-low reset (clears the enable)
//   en_in     requested enable, sampled on the clk falling edge
//   clk_out   gated clock: clk & en (GATE_TRUE) or ~clk & en (GATE_INV)
// The enable changes only while clk is low, so a GATE_TRUE output never
// produces a runt pulse; a GATE_INV output starts its first pulse on the
// very falling edge where the enable rises.
module cpll_clk_gate
   import cpll_pkg::*;
#(
   parameter gate_pol_e POLARITY = GATE_TRUE
) (
   input  logic clk,
   input  logic areset_n,
   input  logic en_in,
   output logic clk_out
);

   logic en;

   always_ff @(negedge clk or negedge areset_n) begin
      if (!areset_n) begin
         en <= 1'b0;
      end else begin
         en <= en_in;
      end
   end

   always_comb begin
      clk_out = 1'b0;
      if (POLARITY == GATE_INV) begin
         clk_out = ~clk & en;
      end else begin
         clk_out = clk & en;
      end
   end

endmodule

// File: rtl/cpll.sv
// cpll: digital stand-in for a PLL built from counters and clock gates.
//   inclk0    reference clock; every register runs on one of its edges
//   areset_n  asynchronous active-low reset
//   clks      cpll_if master: c0 (inclk0/C0_DIV, 50% duty), c1 (gated
//             inclk0), c2 (gated auxiliary clock), locked (sticky lock flag)
// Parameters: C0_DIV (even, >= 2), LOCK_CYCLES (>= 1).
// Macro CPLL_C2_INVERT_EN: when defined c2 = ~inclk0 & en (180 degrees from
// c1); otherwise c2 is identical to c1.
module cpll
   import cpll_pkg::*;
#(
   parameter int C0_DIV      = CPLL_DEF_C0_DIV,
   parameter int LOCK_CYCLES = CPLL_DEF_LOCK_CYCLES
) (
   input  logic   inclk0,
   input  logic   areset_n,
   cpll_if.master clks
);

   if ((C0_DIV < 2) || ((C0_DIV % 2) != 0)) begin : g_bad_c0_div
      $error("cpll: C0_DIV=%0d must be even and at least 2", C0_DIV);
   end
   if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
      $error("cpll: LOCK_CYCLES=%0d must be at least 1", LOCK_CYCLES);
   end

   localparam int unsigned HALF   = C0_DIV / 2;
   localparam int unsigned LOCK_W = cpll_cnt_width(LOCK_CYCLES + 1);
   localparam int unsigned DIV_W  = cpll_cnt_width(HALF);

`ifdef CPLL_C2_INVERT_EN
   localparam gate_pol_e C2_POL = GATE_INV;
`else
   localparam gate_pol_e C2_POL = GATE_TRUE;
`endif

   logic [LOCK_W-1:0] lock_cnt;
   logic              locked;
   logic [DIV_W-1:0]  div_cnt;
   logic              c0;
   logic              c1;
   logic              c2;

   // Counting freezes once locked, so locked stays high until reset.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (!locked) begin
         lock_cnt <= lock_cnt + LOCK_W'(1);
         if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
            locked <= 1'b1;
         end
      end
   end

   // The divider sees locked only from the edge after the one that set it,
   // which places the first c0 rise HALF edges after the locking edge.
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         div_cnt <= '0;
         c0      <= 1'b0;
      end else if (locked) begin
         if (div_cnt == DIV_W'(HALF - 1)) begin
            div_cnt <= '0;
            c0      <= ~c0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   cpll_clk_gate #(.POLARITY(GATE_TRUE)) u_gate_c1 (
      .clk      (inclk0),
      .areset_n (areset_n),
      .en_in    (locked),
      .clk_out  (c1)
   );

   cpll_clk_gate #(.POLARITY(C2_POL)) u_gate_c2 (
      .clk      (inclk0),
      .areset_n (areset_n),
      .en_in    (locked),
      .clk_out  (c2)
   );

   assign clks.c0     = c0;
   assign clks.c1     = c1;
   assign clks.c2     = c2;
   assign clks.locked = locked;

endmodule

// File: tb/tb_cpll.sv
// tb_cpll: scoreboard bench for cpll. Two instances share clock and reset:
//   dut_a  C0_DIV=2, LOCK_CYCLES=16 (defaults)
//   dut_b  C0_DIV=6, LOCK_CYCLES=1  (shortest lock, wider divider)
// Expected outputs come from edge counting since reset release.
module tb_cpll;
   import cpll_pkg::*;

`ifdef CPLL_C2_INVERT_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   localparam int LA = 16;
   localparam int HA = 1;
   localparam int LB = 1;
   localparam int HB = 3;
   localparam int NCYC = 3000;

   typedef struct packed {
      logic locked;
      logic c0;
      logic c1;
      logic c2;
   } obs_t;

   typedef struct {
      obs_t  a;
      obs_t  b;
      int    k;
      string tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb[$];

   cpll_if bus_a ();
   cpll_if bus_b ();

   cpll #(.C0_DIV(2), .LOCK_CYCLES(16)) dut_a (
      .inclk0   (clk),
      .areset_n (rst_n),
      .clks     (bus_a)
   );

   cpll #(.C0_DIV(6), .LOCK_CYCLES(1)) dut_b (
      .inclk0   (clk),
      .areset_n (rst_n),
      .clks     (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // k = rising edges since reset release; lock at edge L; c0 toggles every
   // H edges after that; enables follow one falling edge behind locked.
   function automatic obs_t model(input int k, input int l, input int h,
                                  input bit low, input bit in_rst);
      obs_t o;
      o = '0;
      if (!in_rst && k >= 1) begin
         o.locked = (k >= l);
         o.c0     = (k >= l) && ((((k - l) / h) % 2) == 1);
         if (!low) begin
            o.c1 = (k > l);
            o.c2 = INV ? 1'b0 : (k > l);
         end else begin
            o.c1 = 1'b0;
            o.c2 = INV ? (k >= l) : 1'b0;
         end
      end
      return o;
   endfunction

   function automatic exp_t mk(input int k, input bit low, input bit in_rst,
                               input string tag);
      exp_t e;
      e.a   = model(k, LA, HA, low, in_rst);
      e.b   = model(k, LB, HB, low, in_rst);
      e.k   = k;
      e.tag = tag;
      return e;
   endfunction

   task automatic compare(input exp_t e);
      obs_t ga;
      obs_t gb;
      ga = {bus_a.locked, bus_a.c0, bus_a.c1, bus_a.c2};
      gb = {bus_b.locked, bus_b.c0, bus_b.c1, bus_b.c2};
      checks++;
      if (ga !== e.a) begin
         errors++;
         $display("FAIL %s dut_a k=%0d t=%0t got {locked,c0,c1,c2}=%b required %b",
                  e.tag, e.k, $time, ga, e.a);
      end
      checks++;
      if (gb !== e.b) begin
         errors++;
         $display("FAIL %s dut_b k=%0d t=%0t got {locked,c0,c1,c2}=%b required %b",
                  e.tag, e.k, $time, gb, e.b);
      end
   endtask

   // Monitor: three sample points per cycle, all away from clock edges.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) compare(sb.pop_front());
         #3;
         if (sb.size() != 0) compare(sb.pop_front());
         #2;
         if (sb.size() != 0) compare(sb.pop_front());
      end
   end

   // Stimulus and reference bookkeeping.
   initial begin
      bit in_rst;
      bit rst_now;
      int k;
      int rst_left;
      int waited;

      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      in_rst   = 1'b1;
      rst_left = 5;
      k        = 0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         if (!in_rst) k++;
         rst_now = !in_rst &&
                   ((cyc == 700) || ($urandom_range(0, 249) == 0));
         sb.push_back(mk(k, 1'b0, in_rst, "high_early"));
         sb.push_back(mk(k, 1'b0, in_rst || rst_now, "high_late"));
         sb.push_back(mk(k, 1'b1, in_rst || rst_now, "low_phase"));
         #3;
         if (rst_now) begin
            rst_n    = 1'b0;
            in_rst   = 1'b1;
            rst_left = $urandom_range(1, 3);
         end
         #4;
         if (in_rst) begin
            rst_left--;
            if (rst_left == 0) begin
               rst_n  = 1'b1;
               in_rst = 1'b0;
               k      = 0;
            end
         end
      end

      waited = 0;
      while (sb.size() != 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpll.md
CPLL -- requirements
Module: cpll

Interface
REQ-001 Parameter C0_DIV, default 2, integer divide ratio inclk0→c0; even, ≥2; any other value SHALL stop elaboration with an error.
REQ-002 Parameter LOCK_CYCLES, default 16, inclk0 rising edges from reset release to lock; ≥1.
REQ-003 inclk0  input  1  sole reference clock; every register in the block is clocked by it, on rising or falling edge.
REQ-004 areset_n  input  1  asynchronous, active-low reset.
REQ-005 c0  output  1  divided clock, inclk0/C0_DIV, 50% duty (video clock).
REQ-006 c1  output  1  gated copy of inclk0 (memory clock).
REQ-007 c2  output  1  gated auxiliary memory clock; phase set by the configuration macro.
REQ-008 locked  output  1  high once outputs are valid and stable.

Function
REQ-009 Lock counter SHALL count inclk0 rising edges while locked=0; width sized to hold LOCK_CYCLES.
REQ-010 locked SHALL rise on the LOCK_CYCLES-th inclk0 rising edge after areset_n deasserts; sticky until next reset.
REQ-011 Enable flag en SHALL load locked on each inclk0 falling edge, so gating changes only while inclk0 is low.
REQ-012 c1 SHALL equal inclk0 AND en; first c1 pulse is the first full inclk0 high phase after locked rises; no runt or glitch pulses.
REQ-013 Divider SHALL run only while locked=1; c0 toggles every C0_DIV/2 inclk0 rising edges; first c0 rise occurs on the (C0_DIV/2)-th rising edge after the edge that set locked.
REQ-014 c0 SHALL be a direct flip-flop output, never combinational.
REQ-015 Divider counter SHALL wrap from C0_DIV/2-1 to 0 with no skipped or extra edges; steady-state period exactly C0_DIV inclk0 periods.
REQ-016 Before lock, c0, c1 and c2 SHALL all be held low.

Reset
REQ-017 areset_n=0 SHALL immediately and asynchronously clear: lock counter, locked, en, divider counter, c0.
REQ-018 Consequently c1 and c2 SHALL go low immediately; truncation of an in-flight pulse is accepted.
REQ-019 Reset asserted mid-operation SHALL restart the full lock sequence; no state survives reset.
REQ-020 Reset release needs no synchronizer beyond the registers above; lock counting starts on the first rising edge with areset_n=1.

Configuration
REQ-021 Macro CPLL_C2_INVERT_EN defined: c2 SHALL equal (NOT inclk0) AND en, i.e. 180° shifted from c1; first c2 pulse starts on the falling edge where en rises.
REQ-022 Macro CPLL_C2_INVERT_EN undefined: c2 SHALL be identical to c1.

Structure
REQ-023 Package cpll_pkg SHALL hold default constants CPLL_DEF_C0_DIV=2, CPLL_DEF_LOCK_CYCLES=16 and a counter-width function (ceil log2, minimum 1).
REQ-024 Sub-module cpll_clk_gate SHALL implement the falling-edge-latched glitch-free AND gate, with ports clk, areset_n, en_in, clk_out and a polarity parameter for inversion.
REQ-025 cpll SHALL instantiate cpll_clk_gate twice, once for c1 and once for c2.

Verification
REQ-026 inclk0 100 MHz, areset_n low 50 ns then high -> locked rises on the 16th rising edge after release; c0, c1, c2 low until then.
REQ-027 C0_DIV=2 after lock -> c0 period 20 ns, high time 10 ns, first rise one inclk0 rising edge after locked.
REQ-028 C0_DIV=6 -> c0 period 60 ns, 50% duty, held for 100 periods with no phase drift.
REQ-029 After lock -> c1 matches inclk0 edge-for-edge; without CPLL_C2_INVERT_EN, c2==c1; with it, c2==~inclk0; no pulse shorter than 5 ns.
REQ-030 areset_n pulled low 3 ns into a c1 high phase -> all outputs and locked low within 0 delta cycles; after release, relock again takes 16 edges.
REQ-031 LOCK_CYCLES=1 -> locked rises on the first rising edge after release; C0_DIV=3 -> elaboration error.
